// File: rtl/video_timing_recover_if.sv
// Pixel-stream bundle: incoming de/hsync/vsync and recovered coordinates, markers and geometry.
// The recovery block is the slave side; the source/consumer is the master side.
interface video_timing_recover_if #(
  parameter int CORDW = 12
);
  logic             de;
  logic             hsync;
  logic             vsync;
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             de_out;
  logic             line;
  logic             frame;
  logic [CORDW-1:0] h_res;
  logic [CORDW-1:0] v_res;
  logic             locked;

  modport slave (
    input  de, hsync, vsync,
    output sx, sy, de_out, line, frame, h_res, v_res, locked
  );

  modport master (
    output de, hsync, vsync,
    input  sx, sy, de_out, line, frame, h_res, v_res, locked
  );
endinterface

// File: rtl/video_timing_recover.sv
// Recovers active-area coordinates, line/frame markers and locked geometry from de/hsync/vsync.
// sx/sy/de_out/line/frame lag input de by 2 clk_pix cycles; stream input, no backpressure.
module video_timing_recover #(
  parameter int CORDW       = 12,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 3,
  parameter int MAX_RES     = 4095
) (
  input  logic                  clk_pix,
  input  logic                  rst_n,
  video_timing_recover_if.slave vid
);
  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

  localparam logic [CORDW-1:0] MAXC   = CORDW'(MAX_RES);
  localparam logic [CORDW-1:0] ONE    = CORDW'(1);
  localparam logic [CORDW-1:0] SATC   = {CORDW{1'b1}};
  localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

  logic de_s1_q, hs_s1_q, vs_s1_q, de_s2_q, hs_s2_q, vs_s2_q;
  logic de_rise, de_fall, hs_rise, vs_rise, new_frame;

  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d, hcnt_q, hcnt_d, vcnt_q, vcnt_d, h_first_q, h_first_d;
  logic de_out_q, de_out_d, line_q, line_d, frame_q, frame_d;
  logic vs_pend_q, vs_pend_d, first_line_q, first_line_d, inv_q, inv_d, de_seen_q, de_seen_d;

  state_t           state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [CORDW-1:0] geo_h_q, geo_h_d, geo_v_q, geo_v_d, hres_q, hres_d, vres_q, vres_d;
  logic             locked_q, locked_d, cand_ok, cand_eq;

  // Syncs are normalised to active-high before they reach the edge detectors.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      {de_s1_q, hs_s1_q, vs_s1_q, de_s2_q, hs_s2_q, vs_s2_q} <= '0;
    end else begin
      de_s1_q <= vid.de;
      hs_s1_q <= SYNC_POL ? vid.hsync : ~vid.hsync;
      vs_s1_q <= SYNC_POL ? vid.vsync : ~vid.vsync;
      de_s2_q <= de_s1_q;
      hs_s2_q <= hs_s1_q;
      vs_s2_q <= vs_s1_q;
    end
  end

  assign de_rise   = de_s1_q & ~de_s2_q;
  assign de_fall   = ~de_s1_q & de_s2_q;
  assign hs_rise   = hs_s1_q & ~hs_s2_q;
  assign vs_rise   = vs_s1_q & ~vs_s2_q;
  assign new_frame = vs_pend_q | vs_rise;

  always_comb begin
    sx_d         = sx_q;
    sy_d         = sy_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    h_first_d    = h_first_q;
    first_line_d = first_line_q;
    inv_d        = inv_q;
    de_out_d     = de_s1_q;
    line_d       = de_rise;
    frame_d      = de_rise & new_frame;
    vs_pend_d    = de_rise ? 1'b0 : new_frame;
    de_seen_d    = hs_rise ? de_rise : (de_seen_q | de_rise);

    if (de_rise) sx_d = '0;
    else if (de_s1_q && sx_q != SATC) sx_d = sx_q + ONE;
    if (de_rise) begin
      if (new_frame) sy_d = '0;
      else if (sy_q != SATC) sy_d = sy_q + ONE;
    end
    if (de_rise) hcnt_d = ONE;
    else if (de_s1_q && hcnt_q != MAXC) hcnt_d = hcnt_q + ONE;

    // Frame end wins over any line activity in the same cycle; a coincident de rise is line 0.
    if (vs_rise) begin
      vcnt_d       = de_rise ? ONE : '0;
      first_line_d = 1'b1;
      inv_d        = 1'b0;
    end else begin
      if (de_rise && vcnt_q != MAXC) vcnt_d = vcnt_q + ONE;
      if (de_fall) begin
        if (first_line_q) begin
          h_first_d    = hcnt_q;
          first_line_d = 1'b0;
        end else if (hcnt_q != h_first_q) begin
          inv_d = 1'b1;
        end
      end
      if ((hcnt_d == MAXC && hcnt_q != MAXC) || (vcnt_d == MAXC && vcnt_q != MAXC)) inv_d = 1'b1;
      if (de_rise && de_seen_q && !hs_rise) inv_d = 1'b1;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      {sx_q, sy_q, hcnt_q, vcnt_q, h_first_q} <= '0;
      {de_out_q, line_q, frame_q, vs_pend_q, inv_q, de_seen_q} <= '0;
      first_line_q <= 1'b1;
    end else begin
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      h_first_q    <= h_first_d;
      first_line_q <= first_line_d;
      inv_q        <= inv_d;
      de_out_q     <= de_out_d;
      line_q       <= line_d;
      frame_q      <= frame_d;
      vs_pend_q    <= vs_pend_d;
      de_seen_q    <= de_seen_d;
    end
  end

  assign cand_ok = ~inv_q & (vcnt_q != '0);
  assign cand_eq = (h_first_q == geo_h_q) && (vcnt_q == geo_v_q);

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEEK;
      match_q  <= '0;
      {geo_h_q, geo_v_q, hres_q, vres_q} <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      geo_h_q  <= geo_h_d;
      geo_v_q  <= geo_v_d;
      hres_q   <= hres_d;
      vres_q   <= vres_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      case (state_q)
        SEEK:    state_d = MEASURE;
        MEASURE: if (match_d == LOCK_N) state_d = LOCKED;
        LOCKED:  if (!(cand_ok && cand_eq)) state_d = MEASURE;
        default: state_d = SEEK;
      endcase
    end
  end

  always_comb begin
    match_d  = match_q;
    geo_h_d  = geo_h_q;
    geo_v_d  = geo_v_q;
    hres_d   = hres_q;
    vres_d   = vres_q;
    locked_d = locked_q;
    if (vs_rise) begin
      case (state_q)
        MEASURE: begin
          if (!cand_ok) match_d = '0;
          else if (cand_eq) match_d = match_q + 4'd1;
          else begin
            geo_h_d = h_first_q;
            geo_v_d = vcnt_q;
            match_d = 4'd1;
          end
          if (match_d == LOCK_N) begin
            locked_d = 1'b1;
            hres_d   = geo_h_d;
            vres_d   = geo_v_d;
          end
        end
        // Losing lock keeps the last reported resolution on h_res/v_res.
        LOCKED: if (!(cand_ok && cand_eq)) begin
          locked_d = 1'b0;
          match_d  = cand_ok ? 4'd1 : 4'd0;
          if (cand_ok) begin
            geo_h_d = h_first_q;
            geo_v_d = vcnt_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign vid.sx     = sx_q;
  assign vid.sy     = sy_q;
  assign vid.de_out = de_out_q;
  assign vid.line   = line_q;
  assign vid.frame  = frame_q;
  assign vid.h_res  = hres_q;
  assign vid.v_res  = vres_q;
  assign vid.locked = locked_q;
endmodule
